// File: rtl/bus_responder_pkg.sv
// rtl/bus_responder_pkg.sv - address map, timer register bits and decode types for bus_responder
package bus_responder_pkg;

    localparam logic [15:0] RAM_BASE      = 16'h0000;
    localparam logic [15:0] SEG_ADDR      = 16'hD000;
    localparam logic [15:0] TMR_LO_ADDR   = 16'hD001;
    localparam logic [15:0] TMR_HI_ADDR   = 16'hD002;
    localparam logic [15:0] TMR_CTRL_ADDR = 16'hD003;
    localparam logic [15:0] TMR_STAT_ADDR = 16'hD004;
    localparam logic [15:0] VEC_LO_ADDR   = 16'hFFFC;
    localparam logic [15:0] VEC_HI_ADDR   = 16'hFFFD;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_EXP_BIT    = 0;

    typedef enum logic [2:0] {
        RGN_NONE, RGN_RAM, RGN_SEG, RGN_TMR, RGN_VEC_LO, RGN_VEC_HI
    } region_e;

    typedef enum logic [2:0] {
        TSEL_NONE, TSEL_LO, TSEL_HI, TSEL_CTRL, TSEL_STAT
    } tmr_sel_e;

endpackage

// File: rtl/bus_responder_timer.sv
// rtl/bus_responder_timer.sv - resp_timer: 16-bit reloading down counter with CTRL/STAT registers
module resp_timer
    import bus_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr,
    input  logic       i_rd,
    input  tmr_sel_e   i_sel,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_irq
);

    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic        r_en;
    logic        r_irq_en;
    logic        r_expired;
    logic [15:0] r_count;

    logic        w_wr_ctrl;
    logic        w_en_next;
    logic        w_start;
    logic        w_expire;
    logic [15:0] w_reload;

    assign w_reload  = {r_hi, r_lo};
    assign w_wr_ctrl = i_wr && (i_sel == TSEL_CTRL);
    assign w_en_next = w_wr_ctrl ? i_wdata[CTRL_EN_BIT] : r_en;
    assign w_start   = w_wr_ctrl && i_wdata[CTRL_EN_BIT] && !r_en;
    // A disabling write suppresses an expiry that would otherwise land on the same edge.
    assign w_expire  = r_en && w_en_next && (r_count == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lo      <= 8'd0;
            r_hi      <= 8'd0;
            r_en      <= 1'b0;
            r_irq_en  <= 1'b0;
            r_expired <= 1'b0;
            r_count   <= 16'd0;
        end else begin
            if (i_wr && (i_sel == TSEL_LO)) r_lo <= i_wdata;
            if (i_wr && (i_sel == TSEL_HI)) r_hi <= i_wdata;
            if (w_wr_ctrl) begin
                r_en     <= i_wdata[CTRL_EN_BIT];
                r_irq_en <= i_wdata[CTRL_IRQ_EN_BIT];
            end
            if (w_start || w_expire)
                r_count <= w_reload;
            else if (r_en && w_en_next)
                r_count <= r_count - 16'd1;
            if (w_expire)
                r_expired <= 1'b1;
            else if (i_rd && (i_sel == TSEL_STAT))
                r_expired <= 1'b0;
        end
    end

    always_comb begin
        o_rdata = 8'd0;
        case (i_sel)
            TSEL_LO:   o_rdata = r_lo;
            TSEL_HI:   o_rdata = r_hi;
            TSEL_CTRL: begin
                o_rdata[CTRL_EN_BIT]     = r_en;
                o_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
            end
            TSEL_STAT: o_rdata[STAT_EXP_BIT] = r_expired;
            default:   o_rdata = 8'd0;
        endcase
    end

    assign o_irq = r_expired & r_irq_en;

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - pipelined CPU bus target: RAM, display register, reset vector, optional timer
// Timer present only when BUS_RESPONDER_TIMER_EN is defined.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int          RAM_AW    = 11,
    parameter logic [15:0] RESET_VEC = 16'h8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        rdy,
    output logic        irq,
    output logic [7:0]  seg_val
);

    logic [7:0] r_mem [0:(1<<RAM_AW)-1];
    logic [7:0] r_seg;

    region_e    w_rgn;
    logic       w_wr;
    logic       w_rd;
    logic [7:0] w_rd_data;

    assign w_wr = req && !rw;
    assign w_rd = req && rw;

`ifdef BUS_RESPONDER_TIMER_EN
    tmr_sel_e   w_tsel;
    logic [7:0] w_tmr_rdata;
    logic       w_tmr_irq;

    resp_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr && (w_rgn == RGN_TMR)),
        .i_rd    (w_rd && (w_rgn == RGN_TMR)),
        .i_sel   (w_tsel),
        .i_wdata (wdata),
        .o_rdata (w_tmr_rdata),
        .o_irq   (w_tmr_irq)
    );
    assign irq = w_tmr_irq;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        w_rgn = RGN_NONE;
`ifdef BUS_RESPONDER_TIMER_EN
        w_tsel = TSEL_NONE;
`endif
        if (addr[15:RAM_AW] == RAM_BASE[15:RAM_AW]) begin
            w_rgn = RGN_RAM;
        end else begin
            case (addr)
                SEG_ADDR:      w_rgn = RGN_SEG;
`ifdef BUS_RESPONDER_TIMER_EN
                TMR_LO_ADDR:   begin w_rgn = RGN_TMR; w_tsel = TSEL_LO;   end
                TMR_HI_ADDR:   begin w_rgn = RGN_TMR; w_tsel = TSEL_HI;   end
                TMR_CTRL_ADDR: begin w_rgn = RGN_TMR; w_tsel = TSEL_CTRL; end
                TMR_STAT_ADDR: begin w_rgn = RGN_TMR; w_tsel = TSEL_STAT; end
`endif
                VEC_LO_ADDR:   w_rgn = RGN_VEC_LO;
                VEC_HI_ADDR:   w_rgn = RGN_VEC_HI;
                default:       w_rgn = RGN_NONE;
            endcase
        end
    end

    always_comb begin
        w_rd_data = 8'hFF;
        case (w_rgn)
            RGN_RAM:    w_rd_data = r_mem[addr[RAM_AW-1:0]];
            RGN_SEG:    w_rd_data = r_seg;
`ifdef BUS_RESPONDER_TIMER_EN
            RGN_TMR:    w_rd_data = w_tmr_rdata;
`endif
            RGN_VEC_LO: w_rd_data = RESET_VEC[7:0];
            RGN_VEC_HI: w_rd_data = RESET_VEC[15:8];
            default:    w_rd_data = 8'hFF;
        endcase
    end

    // RAM has no reset; its contents are don't-care after rst.
    always_ff @(posedge clk) begin
        if (w_wr && (w_rgn == RGN_RAM))
            r_mem[addr[RAM_AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy   <= 1'b0;
            rdata <= 8'd0;
            r_seg <= 8'd0;
        end else begin
            rdy <= req;
            if (w_rd)
                rdata <= w_rd_data;
            if (w_wr && (w_rgn == RGN_SEG))
                r_seg <= wdata;
        end
    end

    assign seg_val = r_seg;

endmodule
